display_arbiter: RTL and testbench

//  Shares the board LED bar and two-digit 7-seg display between NREQ requesters
//  (game logic, debug, score). Sits in front of the serial CPLD display driver:
//  its led/dig0/dig1 outputs feed the driver's led/dig0/dig1 inputs.

---
 rtl/display_arbiter.sv | 140 ++++++++++++++
 tb/tb_display_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin owner arbitration for the shared LED bar and 7-seg digits
module display_arbiter #(
   parameter int         NREQ     = 3,
   parameter int         MIN_HOLD = 1024,
   parameter int         MAX_HOLD = 65536,
   parameter int         CNT_W    = 17,
   parameter logic [7:0] IDLE_LED = 8'h00
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] led_in,
   input  logic [4*NREQ-1:0] dig0_in,
   input  logic [4*NREQ-1:0] dig1_in,
   output logic [NREQ-1:0]   gnt,
   output logic              busy,
   output logic [7:0]        led,
   output logic [3:0]        dig0,
   output logic [3:0]        dig1
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_HOLD - 1);
   localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_HOLD - 1);

   typedef enum logic {IDLE, OWN} state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     rr_ptr, rr_nxt;
   logic [PW-1:0]     own_idx, own_nxt;
   logic [CNT_W-1:0]  hold_cnt, hold_nxt;
   logic [NREQ-1:0]   gnt_nxt;
   logic              busy_nxt;
   logic [7:0]        led_nxt;
   logic [3:0]        dig0_nxt, dig1_nxt;

   logic [NREQ-1:0]   cand;
   logic [PW:0]       pick;
   logic              pick_vld;
   logic [PW-1:0]     pick_idx;
   logic              owner_req, release_ok, at_max;

   // Returns {valid, index} of the first set bit at or after ptr, wrapping.
   function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] ptr);
      logic [PW:0] res;
      int          idx;
      res = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NREQ;
         if (r[idx]) res = {1'b1, PW'(idx)};
      end
      return res;
   endfunction

   // While owning, the current owner is masked out so a switch always moves on.
   assign cand       = (state == OWN) ? (req & ~gnt) : req;
   assign pick       = rr_pick(cand, rr_ptr);
   assign pick_vld   = pick[PW];
   assign pick_idx   = pick[PW-1:0];
   assign owner_req  = req[own_idx];
   assign release_ok = !owner_req && (hold_cnt >= MIN_LAST);
   assign at_max     = (hold_cnt == MAX_LAST);

   always_comb begin
      state_nxt = state;
      rr_nxt    = rr_ptr;
      own_nxt   = own_idx;
      hold_nxt  = hold_cnt;
      gnt_nxt   = gnt;
      led_nxt   = led;
      dig0_nxt  = dig0;
      dig1_nxt  = dig1;

      case (state)
         IDLE: begin
            gnt_nxt  = '0;
            led_nxt  = IDLE_LED;
            dig0_nxt = 4'h0;
            dig1_nxt = 4'h0;
            hold_nxt = '0;
         end
         OWN: begin
            if (!at_max) hold_nxt = hold_cnt + CNT_W'(1);
            if (owner_req) begin
               led_nxt  = led_in[8*int'(own_idx) +: 8];
               dig0_nxt = dig0_in[4*int'(own_idx) +: 4];
               dig1_nxt = dig1_in[4*int'(own_idx) +: 4];
            end
            if (release_ok && !pick_vld) begin
               state_nxt = IDLE;
               gnt_nxt   = '0;
               led_nxt   = IDLE_LED;
               dig0_nxt  = 4'h0;
               dig1_nxt  = 4'h0;
               hold_nxt  = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // New grant: from IDLE on any request, from OWN on release or pre-emption.
      if (pick_vld && ((state == IDLE) || (state == OWN && (release_ok || at_max)))) begin
         state_nxt = OWN;
         own_nxt   = pick_idx;
         rr_nxt    = PW'((int'(pick_idx) + 1) % NREQ);
         hold_nxt  = '0;
         gnt_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
         led_nxt   = led_in[8*int'(pick_idx) +: 8];
         dig0_nxt  = dig0_in[4*int'(pick_idx) +: 4];
         dig1_nxt  = dig1_in[4*int'(pick_idx) +: 4];
      end

      busy_nxt = (state_nxt == OWN);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         own_idx  <= '0;
         hold_cnt <= '0;
         gnt      <= '0;
         busy     <= 1'b0;
         led      <= IDLE_LED;
         dig0     <= 4'h0;
         dig1     <= 4'h0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_nxt;
         own_idx  <= own_nxt;
         hold_cnt <= hold_nxt;
         gnt      <= gnt_nxt;
         busy     <= busy_nxt;
         led      <= led_nxt;
         dig0     <= dig0_nxt;
         dig1     <= dig1_nxt;
      end
   end

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - directed self-checking bench for display_arbiter
module tb_display_arbiter;

   localparam logic [7:0] IDLE_PAT = 8'h81;

   logic        clk;
   logic        rstn;
   logic [2:0]  req;
   logic [23:0] led_in;
   logic [11:0] dig0_in;
   logic [11:0] dig1_in;
   logic [2:0]  gnt;
   logic        busy;
   logic [7:0]  led;
   logic [3:0]  dig0;
   logic [3:0]  dig1;

   int n_checks = 0;
   int n_errors = 0;

   display_arbiter #(
      .NREQ(3), .MIN_HOLD(4), .MAX_HOLD(16), .CNT_W(5), .IDLE_LED(IDLE_PAT)
   ) dut (
      .clk(clk), .rstn(rstn), .req(req),
      .led_in(led_in), .dig0_in(dig0_in), .dig1_in(dig1_in),
      .gnt(gnt), .busy(busy), .led(led), .dig0(dig0), .dig1(dig1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_gnt"},  32'(gnt),  32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_led"},  32'(led),  32'(IDLE_PAT));
      check({tag, "_dig0"}, 32'(dig0), 32'h0);
      check({tag, "_dig1"}, 32'(dig1), 32'h0);
   endtask

   logic [2:0] rr_gnt [4];
   logic [7:0] rr_led [4];

   initial begin
      rstn    = 1'b0;
      req     = 3'b000;
      led_in  = {8'hC2, 8'h11, 8'hA0};
      dig0_in = {4'h9, 4'h3, 4'h1};
      dig1_in = {4'h8, 4'h7, 4'h2};
      rr_gnt  = '{3'b001, 3'b010, 3'b100, 3'b001};
      rr_led  = '{8'hA0, 8'hB1, 8'hC2, 8'hA0};

      // 1: reset, then 20 idle cycles
      tick();
      check_idle("rst");
      tick();
      rstn = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      check_idle("idle20");

      // 2: single requester, data tracking
      led_in[15:8] = 8'hA5;
      req = 3'b010;
      tick();
      check("t2_gnt",  32'(gnt),  32'h2);
      check("t2_busy", 32'(busy), 32'h1);
      check("t2_led",  32'(led),  32'hA5);
      check("t2_dig0", 32'(dig0), 32'h3);
      check("t2_dig1", 32'(dig1), 32'h7);
      led_in[15:8] = 8'h3C;
      tick();
      check("t2_track", 32'(led), 32'h3C);
      tick();
      tick();
      req = 3'b000;
      tick();
      check_idle("t2_rel");

      // 3: one-cycle pulse keeps grant for MIN_HOLD cycles with frozen data
      req = 3'b010;
      tick();
      check("t3_gnt0", 32'(gnt), 32'h2);
      check("t3_led0", 32'(led), 32'h3C);
      req = 3'b000;
      led_in[15:8] = 8'hFF;
      for (int i = 1; i < 4; i++) begin
         tick();
         check("t3_hold_gnt", 32'(gnt), 32'h2);
         check("t3_frozen",   32'(led), 32'h3C);
      end
      tick();
      check_idle("t3_end");

      // 4: all requesting from reset, pre-emption every 16 cycles
      rstn = 1'b0;
      #2;
      rstn = 1'b1;
      led_in = {8'hC2, 8'hB1, 8'hA0};
      req = 3'b111;
      tick();
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 16; c++) begin
            check("t4_rr_gnt", 32'(gnt), 32'(rr_gnt[s]));
            if (c == 8) check("t4_rr_led", 32'(led), 32'(rr_led[s]));
            tick();
         end
      end

      // 5: owner releases after MIN_HOLD while another rises -> direct switch
      rstn = 1'b0;
      #2;
      rstn = 1'b1;
      req = 3'b001;
      tick();
      check("t5_gnt0", 32'(gnt), 32'h1);
      for (int i = 0; i < 5; i++) tick();
      req = 3'b100;
      tick();
      check("t5_switch", 32'(gnt), 32'h4);
      check("t5_led",    32'(led), 32'hC2);
      check("t5_dig0",   32'(dig0), 32'h9);
      req = 3'b000;
      for (int i = 1; i < 4; i++) begin
         tick();
         check("t5_restart", 32'(gnt), 32'h4);
      end
      tick();
      check_idle("t5_end");

      // 6: asynchronous reset mid-OWN, rr pointer restarts
      req = 3'b010;
      tick();
      check("t6_gnt", 32'(gnt), 32'h2);
      #3;
      rstn = 1'b0;
      #1;
      check_idle("t6_async");
      #1;
      rstn = 1'b1;
      req = 3'b100;
      tick();
      check("t6_after", 32'(gnt), 32'h4);
      #2;
      rstn = 1'b0;
      #1;
      rstn = 1'b1;
      req = 3'b101;
      tick();
      check("t6_ptr0", 32'(gnt), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
